aes_cipher_iter: RTL and testbench
==================================

Name: aes_cipher_iter

Overview:
Iterative AES encryption datapath. It consumes the full expanded key schedule `w` produced by the combinational key expansion stage and computes one cipher round per clock. The block sits directly downstream of key expansion and upstream of the SPI result buffer. It uses a start/done handshake and supports AES-128/192/256 through the same Nk/Nr parameters as the key expansion.

Parameters:
Nk, 4, key length in 32-bit words (4/6/8); carried for consistency with the key expansion stage and not otherwise used in the datapath
Nr, 10, number of rounds (10/12/14); must match the key expansion instance

Ports:
clk  input  1  system clock, rising-edge
reset  input  1  synchronous, active-high reset
start  input  1  request to encrypt data_in; sampled only in IDLE
data_in  input  [0:127]  plaintext block; bits 0:7 = byte 0; state is column-major, byte k -> row k%4, column k/4
w  input  [0:128*(Nr+1)-1]  expanded key schedule; round key r = w[r*128 +: 128]
busy  output  1  high while rounds are in progress
done  output  1  one-cycle pulse when data_out becomes valid
data_out  output  [0:127]  ciphertext, held stable until the next completion or reset

Behaviour:
- Interface: one clock `clk`; reset `reset` is synchronous and active-high.
- Reset values: busy=0, done=0, data_out=0, internal state=0, round counter=0, FSM=IDLE.
- FSM states: IDLE and RUN.
- IDLE:
  - done is forced to 0 after a single cycle.
  - If start=1 at an edge: state <= data_in ^ w[0:127] (initial AddRoundKey), round <= 1, busy <= 1, go to RUN.
- RUN, for round r < Nr, one edge per round: state <= MixColumns(ShiftRows(SubBytes(state))) ^ w[r*128 +: 128], then r <= r+1.
- RUN, for r == Nr (final round):
  - data_out <= ShiftRows(SubBytes(state)) ^ w[Nr*128 +: 128] (no MixColumns).
  - done <= 1, busy <= 0, go to IDLE.
- Latency: start sampled at edge k gives done=1 and valid data_out after edge k+Nr.
  - Throughput is one block per Nr+1 cycles.
  - A start asserted in the same cycle as done is not accepted, because the FSM is still in RUN.
- Transform definitions:
  - SubBytes uses the standard FIPS-197 S-box, a 256-entry table; one 128-bit S-box layer is shared by all rounds.
  - ShiftRows cyclically rotates row k left by k bytes.
  - MixColumns multiplies each column by the fixed polynomial {03}x^3+{01}x^2+{01}x+{02} over GF(2^8), using xtime with reduction by 8'h1b.
- start while busy=1 is ignored; no queueing, no error flag.
- data_in is sampled only on the accepting edge; later changes have no effect.
- w must be held stable from the accepting edge until done. The block does not latch w; the upstream key register guarantees this.
- reset asserted mid-operation aborts the block at the next edge:
  - all outputs return to reset values and the FSM goes to IDLE;
  - no done pulse is issued for the aborted block.
- reset and start high together: reset wins.
- data_out keeps its last ciphertext through IDLE and through a subsequent RUN until the new final round overwrites it.

Test Plan:
- AES-128 (FIPS-197 App. B): key 2b7e151628aed2a6abf7158809cf4f3c, pt 3243f6a8885a308d313198a2e0370734, one-cycle start -> done pulse exactly 10 edges later, data_out = 3925841d02dc09fbdc118597196a0b32, busy high for 10 cycles.
- AES-128/192/256 (App. C), pt 00112233445566778899aabbccddeeff with keys 000102..0f / ..17 / ..1f, Nk/Nr = 4/10, 6/12, 8/14 -> ciphertexts 69c4e0d86a7b0430d8cdb78070b4c55a, dda97ca4864cdfe06eaf70a0ec0d7191, 8ea2b7ca516745bfeafc49904b496089 respectively; latency Nr each.
- start held high continuously, AES-128 vector -> blocks complete every 11 cycles; done never high for two consecutive cycles; a start pulse inserted mid-RUN is ignored and the result is unchanged.
- Reset at round 5 of a run -> next cycle busy=0, done=0, data_out=0; no done pulse follows. A fresh start afterwards produces the correct ciphertext.
- data_in changed every cycle during RUN -> data_out equals the encryption of the value present at the accepting edge; data_out holds that value for 20 idle cycles afterwards.

Source files
------------

// File: rtl/aes_cipher_iter.sv
// Iterative AES encryption core: one cipher round per clock.
// Consumes the full expanded key schedule from the key expansion stage and
// produces the ciphertext with a start/done handshake. AES-128/192/256 are
// selected by Nk/Nr, which must match the key expansion instance.
module aes_cipher_iter #(
   parameter int Nk = 4,
   parameter int Nr = 10
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  start,
   input  logic [0:127]          data_in,
   input  logic [0:128*(Nr+1)-1] w,
   output logic                  busy,
   output logic                  done,
   output logic [0:127]          data_out
);

   localparam int RW = $clog2(Nr + 1);

   // An Nk/Nr pair that disagrees with the key expansion is a build error.
   if (Nr != Nk + 6) begin : g_cfg_mismatch
      $error("aes_cipher_iter: Nr must equal Nk + 6");
   end

   // Standard FIPS-197 S-box, byte 0 at the left.
   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef enum logic {S_IDLE, S_RUN} state_t;

   state_t          r_fsm;
   logic [RW-1:0]   r_round;
   logic [0:127]    r_state;
   logic [0:127]    r_data_out;
   logic            r_busy;
   logic            r_done;

   logic [0:127]    w_keys [0:Nr];
   logic [0:127]    w_rk;
   logic [0:127]    w_sb;
   logic [0:127]    w_sr;
   logic [0:127]    w_mc;

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[{b, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [0:127] sub_bytes(input logic [0:127] s);
      logic [0:127] o;
      for (int k = 0; k < 16; k++) o[k*8 +: 8] = sbox(s[k*8 +: 8]);
      return o;
   endfunction

   // Byte k sits at row k%4, column k/4; row r rotates left by r columns.
   function automatic logic [0:127] shift_rows(input logic [0:127] s);
      logic [0:127] o;
      for (int r = 0; r < 4; r++)
         for (int c = 0; c < 4; c++)
            o[(r + 4*c)*8 +: 8] = s[(r + 4*((c + r) % 4))*8 +: 8];
      return o;
   endfunction

   function automatic logic [0:127] mix_columns(input logic [0:127] s);
      logic [0:127] o;
      logic [7:0]   a0, a1, a2, a3;
      for (int c = 0; c < 4; c++) begin
         a0 = s[(4*c + 0)*8 +: 8];
         a1 = s[(4*c + 1)*8 +: 8];
         a2 = s[(4*c + 2)*8 +: 8];
         a3 = s[(4*c + 3)*8 +: 8];
         o[(4*c + 0)*8 +: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
         o[(4*c + 1)*8 +: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
         o[(4*c + 2)*8 +: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
         o[(4*c + 3)*8 +: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
      end
      return o;
   endfunction

   for (genvar g = 0; g <= Nr; g++) begin : g_keys
      assign w_keys[g] = w[g*128 +: 128];
   end

   // One shared round datapath; the final round simply skips MixColumns.
   assign w_rk = w_keys[r_round];
   assign w_sb = sub_bytes(r_state);
   assign w_sr = shift_rows(w_sb);
   assign w_mc = mix_columns(w_sr);

   // Control FSM and round state: IDLE accepts a block, RUN does one round per edge.
   always_ff @(posedge clk) begin
      if (reset) begin
         r_fsm      <= S_IDLE;
         r_round    <= '0;
         r_state    <= '0;
         r_data_out <= '0;
         r_busy     <= 1'b0;
         r_done     <= 1'b0;
      end else begin
         case (r_fsm)
            S_IDLE: begin
               r_done <= 1'b0;
               if (start) begin
                  r_state <= data_in ^ w_keys[0];
                  r_round <= RW'(1);
                  r_busy  <= 1'b1;
                  r_fsm   <= S_RUN;
               end
            end
            S_RUN: begin
               if (r_round == RW'(Nr)) begin
                  r_data_out <= w_sr ^ w_rk;
                  r_done     <= 1'b1;
                  r_busy     <= 1'b0;
                  r_round    <= '0;
                  r_fsm      <= S_IDLE;
               end else begin
                  r_state <= w_mc ^ w_rk;
                  r_round <= r_round + 1'b1;
               end
            end
            default: r_fsm <= S_IDLE;
         endcase
      end
   end

   assign busy     = r_busy;
   assign done     = r_done;
   assign data_out = r_data_out;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// Directed bench for aes_cipher_iter: FIPS-197 vectors for AES-128/192/256
// plus handshake corner cases (held start, ignored start, abort, input hold).
module tb_aes_cipher_iter;

   localparam logic [0:2047] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   typedef struct {
      int            inst;
      int            nk;
      logic [0:255]  key;
      logic [0:127]  pt;
      logic [0:127]  ct;
      string         name;
   } vec_t;

   logic          clk = 1'b0;
   logic          reset;
   logic          start_v [3];
   logic [0:127]  din_v   [3];
   logic          busy_v  [3];
   logic          done_v  [3];
   logic [0:127]  dout_v  [3];
   logic [0:1407] w128;
   logic [0:1663] w192;
   logic [0:1919] w256;

   int n_checks = 0;
   int n_errors = 0;

   vec_t vecs [4];

   always #5 clk = ~clk;

   aes_cipher_iter #(.Nk(4), .Nr(10)) u128 (
      .clk(clk), .reset(reset), .start(start_v[0]), .data_in(din_v[0]), .w(w128),
      .busy(busy_v[0]), .done(done_v[0]), .data_out(dout_v[0]));
   aes_cipher_iter #(.Nk(6), .Nr(12)) u192 (
      .clk(clk), .reset(reset), .start(start_v[1]), .data_in(din_v[1]), .w(w192),
      .busy(busy_v[1]), .done(done_v[1]), .data_out(dout_v[1]));
   aes_cipher_iter #(.Nk(8), .Nr(14)) u256 (
      .clk(clk), .reset(reset), .start(start_v[2]), .data_in(din_v[2]), .w(w256),
      .busy(busy_v[2]), .done(done_v[2]), .data_out(dout_v[2]));

   function automatic logic [7:0] tb_sbox(input logic [7:0] b);
      return SBOX[{b, 3'b000} +: 8];
   endfunction

   function automatic logic [31:0] sub_word(input logic [31:0] x);
      return {tb_sbox(x[31:24]), tb_sbox(x[23:16]), tb_sbox(x[15:8]), tb_sbox(x[7:0])};
   endfunction

   // FIPS-197 key expansion; key is left-aligned in 256 bits.
   function automatic logic [0:1919] expand(input logic [0:255] key, input int nk);
      logic [31:0]   wd [60];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [0:1919] r;
      int            nwords;
      nwords = 4 * (nk + 7);
      rc = 8'h01;
      r = '0;
      for (int i = 0; i < 60; i++) wd[i] = '0;
      for (int i = 0; i < nk; i++) wd[i] = key[i*32 +: 32];
      for (int i = nk; i < nwords; i++) begin
         t = wd[i-1];
         if (i % nk == 0) begin
            t = sub_word({t[23:0], t[31:24]}) ^ {rc, 24'h0};
            rc = {rc[6:0], 1'b0} ^ (rc[7] ? 8'h1b : 8'h00);
         end else if (nk > 6 && i % nk == 4) begin
            t = sub_word(t);
         end
         wd[i] = wd[i-nk] ^ t;
      end
      for (int i = 0; i < nwords; i++) r[i*32 +: 32] = wd[i];
      return r;
   endfunction

   task automatic check128(input string nm, input logic [0:127] act, input logic [0:127] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic check_int(input string nm, input int act, input int exp);
      n_checks++;
      if (act != exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic load_key(input int inst, input int nk, input logic [0:255] key);
      logic [0:1919] wf;
      wf = expand(key, nk);
      case (inst)
         0:       w128 = wf[0 +: 1408];
         1:       w192 = wf[0 +: 1664];
         default: w256 = wf;
      endcase
   endtask

   // One block: start pulse, count latency/busy, optionally pulse start at a
   // given RUN cycle and/or scramble data_in while running.
   task automatic run_vec(input int i, input logic [0:127] pt, input logic [0:127] ct,
                          input int nr, input int pulse_at, input bit scramble,
                          input string name);
      int lat;
      int busy_cnt;
      @(negedge clk);
      din_v[i]   = pt;
      start_v[i] = 1'b1;
      @(negedge clk);
      start_v[i] = 1'b0;
      lat = 0;
      busy_cnt = 0;
      while (done_v[i] !== 1'b1 && lat < 40) begin
         if (busy_v[i] === 1'b1) busy_cnt++;
         if (scramble) din_v[i] = {$urandom, $urandom, $urandom, $urandom};
         start_v[i] = (lat == pulse_at);
         @(negedge clk);
         lat++;
      end
      start_v[i] = 1'b0;
      check_int($sformatf("%s latency", name), lat, nr);
      check_int($sformatf("%s busy cycles", name), busy_cnt, nr);
      check128($sformatf("%s data_out", name), dout_v[i], ct);
      check_int($sformatf("%s busy at done", name), int'(busy_v[i]), 0);
      @(negedge clk);
      check_int($sformatf("%s done one cycle", name), int'(done_v[i]), 0);
      check_int($sformatf("%s no restart", name), int'(busy_v[i]), 0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int            dn_times [3];
      int            ndone;
      int            consec;
      int            bad;
      int            extra;
      logic          prev_done;
      logic [0:127]  ct_b;
      logic [0:127]  pt_b;

      pt_b = 128'h3243f6a8885a308d313198a2e0370734;
      ct_b = 128'h3925841d02dc09fbdc118597196a0b32;
      vecs[0] = '{0, 4, {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0}, pt_b, ct_b, "aes128_appB"};
      vecs[1] = '{0, 4, {128'h000102030405060708090a0b0c0d0e0f, 128'h0},
                  128'h00112233445566778899aabbccddeeff,
                  128'h69c4e0d86a7b0430d8cdb78070b4c55a, "aes128_appC"};
      vecs[2] = '{1, 6, {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0},
                  128'h00112233445566778899aabbccddeeff,
                  128'hdda97ca4864cdfe06eaf70a0ec0d7191, "aes192_appC"};
      vecs[3] = '{2, 8, 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
                  128'h00112233445566778899aabbccddeeff,
                  128'h8ea2b7ca516745bfeafc49904b496089, "aes256_appC"};

      // Reset with start high on one instance: reset must win.
      reset = 1'b1;
      w128 = '0;
      w192 = '0;
      w256 = '0;
      for (int i = 0; i < 3; i++) begin
         start_v[i] = 1'b0;
         din_v[i]   = '0;
      end
      start_v[0] = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 3; i++) begin
         check_int($sformatf("reset busy[%0d]", i), int'(busy_v[i]), 0);
         check_int($sformatf("reset done[%0d]", i), int'(done_v[i]), 0);
         check128($sformatf("reset data_out[%0d]", i), dout_v[i], '0);
      end
      reset = 1'b0;
      start_v[0] = 1'b0;
      @(negedge clk);
      check_int("reset wins over start", int'(busy_v[0]), 0);

      // Known-answer vectors.
      for (int v = 0; v < 4; v++) begin
         load_key(vecs[v].inst, vecs[v].nk, vecs[v].key);
         run_vec(vecs[v].inst, vecs[v].pt, vecs[v].ct, vecs[v].nk + 6, -1, 1'b0, vecs[v].name);
      end

      // Start pulses mid-RUN and on the final-round edge are ignored.
      load_key(0, 4, vecs[0].key);
      run_vec(0, pt_b, ct_b, 10, 5, 1'b0, "pulse_mid_run");
      run_vec(0, pt_b, ct_b, 10, 9, 1'b0, "pulse_final_edge");

      // Start held high: one block per 11 cycles, done never back-to-back.
      @(negedge clk);
      din_v[0]   = pt_b;
      start_v[0] = 1'b1;
      ndone = 0;
      consec = 0;
      bad = 0;
      prev_done = 1'b0;
      for (int k = 0; k < 3; k++) dn_times[k] = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         if (done_v[0] === 1'b1) begin
            if (prev_done) consec++;
            if (ndone < 3) dn_times[ndone] = cyc;
            ndone++;
            if (dout_v[0] !== ct_b) bad++;
         end
         prev_done = done_v[0];
      end
      start_v[0] = 1'b0;
      check_int("held start done count", ndone, 3);
      check_int("held start first done", dn_times[0], 10);
      check_int("held start period 1", dn_times[1] - dn_times[0], 11);
      check_int("held start period 2", dn_times[2] - dn_times[1], 11);
      check_int("held start back-to-back done", consec, 0);
      check_int("held start wrong data", bad, 0);
      repeat (15) @(negedge clk);
      check_int("held start drained", int'(busy_v[0]), 0);

      // Abort at round 5.
      @(negedge clk);
      din_v[0]   = pt_b;
      start_v[0] = 1'b1;
      @(negedge clk);
      start_v[0] = 1'b0;
      repeat (4) @(negedge clk);
      check_int("abort busy before reset", int'(busy_v[0]), 1);
      check128("data_out held during run", dout_v[0], ct_b);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      check_int("abort busy", int'(busy_v[0]), 0);
      check_int("abort done", int'(done_v[0]), 0);
      check128("abort data_out", dout_v[0], '0);
      extra = 0;
      for (int cyc = 0; cyc < 15; cyc++) begin
         @(negedge clk);
         if (done_v[0] === 1'b1) extra++;
      end
      check_int("abort no done pulse", extra, 0);
      run_vec(0, pt_b, ct_b, 10, -1, 1'b0, "after_abort");

      // data_in scrambled during RUN and IDLE; result and hold unaffected.
      run_vec(0, pt_b, ct_b, 10, -1, 1'b1, "scrambled_din");
      bad = 0;
      for (int cyc = 0; cyc < 20; cyc++) begin
         din_v[0] = {$urandom, $urandom, $urandom, $urandom};
         @(negedge clk);
         if (dout_v[0] !== ct_b) bad++;
      end
      check_int("data_out hold 20 idle cycles", bad, 0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
